// File: rtl/aes_inv_key_sched.sv
// Purpose: walks the AES-128 key schedule backwards, emitting round keys 10 down to 0.
// Latency: first key (round 10) one cycle after start; one new key per accepted cycle after that.
// Backpressure: key_out/round_out hold while key_valid && !key_ready; start is ignored while busy.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   start, key_in     begin a schedule from the round-10 key {w0,w1,w2,w3} (w0 in [127:96])
//   key_valid/ready   valid-ready handshake on key_out/round_out
//   key_out           current round key, same packing as key_in
//   round_out         round index of key_out, 10 down to 0
//   busy              high whenever a schedule is in progress
//   done              one-cycle pulse after the round-0 key is accepted
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Forward AES S-box; the inverse schedule still uses the forward SubWord.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    // One inverse schedule step from the current round key.
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [31:0]  rot_w, sub_w;
    logic [127:0] prev_key;

    always_comb begin
        {w0, w1, w2, w3} = key_q;
        w3_n  = w3 ^ w2;
        w2_n  = w2 ^ w1;
        w1_n  = w1 ^ w0;
        rot_w = {w3_n[23:0], w3_n[31:24]};
        sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
        w0_n  = w0 ^ sub_w ^ {rcon(round_q), 24'h000000};
        prev_key = {w0_n, w1_n, w2_n, w3_n};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    key_d   = key_in;
                    round_d = 4'd10;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round_q == 4'd0) begin
                        // Final key accepted: round_out stays at 0, never wraps.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign key_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign key_out   = key_q;
    assign round_out = round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Purpose: self-checking bench for aes_inv_key_sched against a word-array key expansion model.
// Latency: model expects round 10 one cycle after start, then one key per accepted cycle.
// Backpressure: random and directed key_ready stalls; start pulses while busy must be ignored.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready = 1'b0;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R0B = 128'h000102030405060708090a0b0c0d0e0f;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] sbox_tab [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv; s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_tab[x] = s ^ 8'h63;
        end
    endtask

    // Round-r key from the round-10 key: run the standard expansion w[i] = w[i+4] ^ T(w[i+3]) backwards.
    function automatic logic [127:0] inv_round_key(input logic [127:0] k10, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc [1:10];
        rc[1] = 8'h01;
        for (int n = 2; n <= 10; n++)
            rc[n] = {rc[n-1][6:0], 1'b0} ^ (rc[n-1][7] ? 8'h1b : 8'h00);
        {w[40], w[41], w[42], w[43]} = k10;
        for (int i = 39; i >= 0; i--) begin
            t = w[i+3];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc[i/4 + 1], 24'h000000};
            end
            w[i] = w[i+4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Behavioural model: active flag, current round, captured round-10 key.
    bit           m_active = 1'b0;
    bit           m_done = 1'b0;
    int           m_round = 0;
    logic [127:0] m_k10 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_round  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_round  = 10;
                    m_k10    = key_in;
                end
            end else if (key_ready) begin
                if (m_round == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_round--;
                end
            end
        end
    end

    // Keys observed on accepted handshakes, indexed by round.
    logic [127:0] obs [0:10];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_key_valid", 128'(key_valid), 128'(0));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_done", 128'(done), 128'(0));
            check("rst_round_out", 128'(round_out), 128'(0));
            check("rst_key_out", key_out, 128'(0));
        end else begin
            check("key_valid", 128'(key_valid), 128'(m_active));
            check("busy", 128'(busy), 128'(m_active));
            check("done", 128'(done), 128'(m_done));
            if (m_active) begin
                check("round_out", 128'(round_out), 128'(m_round));
                check("key_out", key_out, inv_round_key(m_k10, m_round));
            end
            if (key_valid && key_ready && round_out <= 4'd10) obs[round_out] = key_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input logic [3:0] r, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (key_valid && round_out == r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    initial begin
        build_sbox();
        // Pin the model against known constants.
        check("model_sbox_00", 128'(sbox_tab[8'h00]), 128'(8'h63));
        check("model_sbox_53", 128'(sbox_tab[8'h53]), 128'(8'hed));
        check("model_r9", inv_round_key(K1, 9), R9);
        check("model_r0", inv_round_key(K1, 0), R0);

        #3;
        check("reset_key_valid", 128'(key_valid), 128'(0));
        check("reset_key_out", key_out, 128'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Full run with key_ready high, then back-to-back start in the done cycle.
        key_ready = 1'b1;
        key_in = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_round", 128'(round_out), 128'(10));
        check("first_key", key_out, K1);
        wait_done("run1_done");
        check("run1_busy_in_done", 128'(busy), 128'(0));
        check("run1_r10", obs[10], K1);
        check("run1_r9", obs[9], R9);
        check("run1_r1", obs[1], R1);
        check("run1_r0", obs[0], R0);
        key_in = K2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_accept", 128'(key_valid), 128'(1));
        wait_done("run2_done");
        check("run2_r0", obs[0], R0B);

        // Backpressure at round 9, ignored start mid-run and during the final handshake.
        key_in = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd9, "run3_r9");
        key_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_key", key_out, R9);
            check("stall_round", 128'(round_out), 128'(9));
        end
        key_ready = 1'b1;
        tick();
        check("resume_round", 128'(round_out), 128'(8));
        wait_round(4'd5, "run3_r5");
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd0, "run3_r0");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run3_done", 128'(done), 128'(1));
        check("run3_r0", obs[0], R0);
        tick();
        check("run3_idle", 128'(key_valid), 128'(0));

        // Asynchronous reset in the middle of a schedule.
        key_in = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd6, "run4_r6");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_key_valid", 128'(key_valid), 128'(0));
        check("async_busy", 128'(busy), 128'(0));
        check("async_round", 128'(round_out), 128'(0));
        check("async_key", key_out, 128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_idle", 128'(key_valid), 128'(0));
        end

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            start     = ($urandom_range(0, 7) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            key_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  asynchronous reset, active-low.
REQ-003 SHALL provide start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-004 SHALL provide key_in  input  128  round-10 key {w0,w1,w2,w3}, w0 in [127:96], byte 0 in [127:120].
REQ-005 SHALL provide key_ready  input  1  consumer accepts key_out this cycle.
REQ-006 SHALL provide key_valid  output  1  key_out and round_out hold a valid round key.
REQ-007 SHALL provide key_out  output  128  current round key, same word/byte packing as key_in.
REQ-008 SHALL provide round_out  output  4  round index of key_out, 10 down to 0.
REQ-009 SHALL provide busy  output  1  high in any state other than IDLE.
REQ-010 SHALL provide done  output  1  one-cycle pulse after round-0 key is accepted.

Function
REQ-011 SHALL implement states IDLE and EMIT; IDLE -> EMIT on start; EMIT -> IDLE on handshake (key_valid && key_ready) with round_out==0.
REQ-012 On start in IDLE, SHALL register key_in as key_out, round_out=10, key_valid=1 on the next cycle (1-cycle latency).
REQ-013 key_valid SHALL equal 1 exactly while in EMIT.
REQ-014 key_out and round_out SHALL hold stable while key_valid=1 and key_ready=0.
REQ-015 On handshake with round_out=r>0, SHALL load round r-1 key next cycle; one key per accepted cycle, no bubbles.
REQ-016 Inverse step from {w0,w1,w2,w3} of round r: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{Rcon[r],00,00,00}.
REQ-017 RotWord SHALL map bytes {a,b,c,d} -> {b,c,d,a}; SubWord SHALL apply the forward AES S-box to each of 4 bytes (4 parallel lookups).
REQ-018 Rcon[r] for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36; selected by round_out.
REQ-019 done SHALL assert for exactly the one cycle following the round-0 handshake; busy deasserts in that same cycle.
REQ-020 start while busy=1 SHALL be ignored, including in the cycle of the final handshake; key_in is not sampled then.
REQ-021 start asserted in the cycle done=1 (state IDLE) SHALL be accepted normally.
REQ-022 round_out SHALL never decrement below 0; no wrap to 15.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, key_valid=0, busy=0, done=0, round_out=0, key_out=0, regardless of clk.
REQ-024 Reset mid-schedule SHALL discard the schedule; after release the block waits for a new start.
REQ-025 After reset release, first start SHALL behave per REQ-012 with no residual state.

Verification
REQ-026 Full run, key_ready=1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start -> 11 consecutive keys; r10=d014f9a8..., r9=ac7766f319fadc2128d12941575c006e, r1=a0fafe1788542cb123a339392a6c7605, r0=2b7e151628aed2a6abf7158809cf4f3c; done pulse next cycle.
REQ-027 Backpressure: key_ready=0 for 3 cycles at round 9 -> key_out stays ac7766f3..., round_out=9; resumes at r8 after handshake.
REQ-028 Start while busy: pulse start with different key_in at round 5 -> sequence unaffected, final key still 2b7e1516....
REQ-029 Reset mid-run: rst_n=0 asynchronously at round 6 -> all outputs zero immediately; no key_valid until next start.
REQ-030 Back-to-back: start in done cycle with key_in=13111d7fe3944a17f307a78b4d2b30c5 -> round-0 output 000102030405060708090a0b0c0d0e0f.
